// File: rtl/decode_stage.sv
// Instruction-decode stage: register file, immediate generator, control decoder,
// load-use hazard detection, flush squashing and the ID/EX pipeline register.
module decode_stage #(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_pipe_PC,
  input  logic [31:0] i_pipe_Instruction,
  input  logic [4:0]  i_pipe_Reg1,
  input  logic [4:0]  i_pipe_Reg2,
  input  logic        i_wb_RegWrite,
  input  logic [4:0]  i_wb_Rd,
  input  logic [31:0] i_wb_Data,
  input  logic        i_ctr_Flush,
  output logic        o_ctr_HoldPC,
  output logic        o_ctr_HoldIFIDReg,
  output logic [31:0] o_pipe_PC,
  output logic [31:0] o_pipe_Rs1Data,
  output logic [31:0] o_pipe_Rs2Data,
  output logic [31:0] o_pipe_Imm,
  output logic [4:0]  o_pipe_Rs1,
  output logic [4:0]  o_pipe_Rs2,
  output logic [4:0]  o_pipe_Rd,
  output logic [2:0]  o_pipe_Funct3,
  output logic [3:0]  o_pipe_ALUOp,
  output logic        o_pipe_ALUSrcA,
  output logic        o_pipe_ALUSrcB,
  output logic        o_pipe_RegWrite,
  output logic        o_pipe_MemRead,
  output logic        o_pipe_MemWrite,
  output logic        o_pipe_MemToReg,
  output logic        o_pipe_Branch,
  output logic        o_pipe_Jump,
  output logic        o_pipe_Jalr,
  output logic        o_pipe_Illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        illegal;
  } id_ex_t;

  logic [31:0] rf [32];
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic   rs1_used;
  logic   rs2_used;
  logic   writes_rd;
  logic   bubble_in;
  logic   load_use;
  logic   squash_now;
  logic   r_SquashNext;
  id_ex_t dec;
  id_ex_t r_id_ex;

  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       alt_sub,
                                                 input logic       alt_sra);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt_sub ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt_sra ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Register file: x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (i_wb_RegWrite && (i_wb_Rd != 5'd0)) begin
      rf[i_wb_Rd] <= i_wb_Data;
    end
  end

  always_comb begin
    rs1_data = rf[i_pipe_Reg1];
    if (i_pipe_Reg1 == 5'd0) begin
      rs1_data = '0;
    end else if (WB_BYPASS && i_wb_RegWrite && (i_wb_Rd == i_pipe_Reg1)) begin
      rs1_data = i_wb_Data;
    end
  end

  always_comb begin
    rs2_data = rf[i_pipe_Reg2];
    if (i_pipe_Reg2 == 5'd0) begin
      rs2_data = '0;
    end else if (WB_BYPASS && i_wb_RegWrite && (i_wb_Rd == i_pipe_Reg2)) begin
      rs2_data = i_wb_Data;
    end
  end

  assign instr     = i_pipe_Instruction;
  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign bubble_in = (instr == 32'd0);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec       = '0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    dec.pc       = i_pipe_PC;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.funct3   = funct3;
    dec.alu_op   = ALU_ADD;
    case (opcode)
      OPC_LUI: begin
        dec.alu_op    = ALU_PASSB;
        dec.alu_src_b = 1'b1;
        dec.imm       = imm_u;
        writes_rd     = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.imm       = imm_u;
        writes_rd     = 1'b1;
      end
      OPC_JAL: begin
        dec.jump      = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.imm       = imm_j;
        writes_rd     = 1'b1;
      end
      OPC_JALR: begin
        dec.jump      = 1'b1;
        dec.jalr      = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.imm       = imm_i;
        writes_rd     = 1'b1;
        rs1_used      = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        dec.imm    = imm_b;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
      end
      OPC_LOAD: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.imm        = imm_i;
        writes_rd      = 1'b1;
        rs1_used       = 1'b1;
      end
      OPC_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.imm       = imm_s;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      OPC_OPIMM: begin
        // instr[30] is part of the immediate except for shifts, so it only selects SRA.
        dec.alu_op    = alu_from_funct3(funct3, 1'b0, instr[30]);
        dec.alu_src_b = 1'b1;
        dec.imm       = imm_i;
        writes_rd     = 1'b1;
        rs1_used      = 1'b1;
      end
      OPC_OP: begin
        dec.alu_op = alu_from_funct3(funct3, instr[30], instr[30]);
        writes_rd  = 1'b1;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Unused indices are zeroed so forwarding never matches a stale field.
    dec.reg_write = writes_rd;
    dec.rd        = writes_rd ? instr[11:7] : 5'd0;
    dec.rs1       = rs1_used ? i_pipe_Reg1 : 5'd0;
    dec.rs2       = rs2_used ? i_pipe_Reg2 : 5'd0;
  end

  assign load_use = r_id_ex.mem_read && (r_id_ex.rd != 5'd0) &&
                    ((rs1_used && (r_id_ex.rd == i_pipe_Reg1)) ||
                     (rs2_used && (r_id_ex.rd == i_pipe_Reg2)));

  // IF/ID is wrong-path during the redirect cycle and the one after it.
  assign squash_now = i_ctr_Flush || r_SquashNext;

  assign o_ctr_HoldPC      = load_use && !squash_now;
  assign o_ctr_HoldIFIDReg = load_use && !squash_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_ex      <= '0;
      r_SquashNext <= 1'b0;
    end else begin
      r_SquashNext <= i_ctr_Flush;
      if (squash_now || load_use || bubble_in) begin
        r_id_ex <= '0;
      end else begin
        r_id_ex <= dec;
      end
    end
  end

  assign o_pipe_PC       = r_id_ex.pc;
  assign o_pipe_Rs1Data  = r_id_ex.rs1_data;
  assign o_pipe_Rs2Data  = r_id_ex.rs2_data;
  assign o_pipe_Imm      = r_id_ex.imm;
  assign o_pipe_Rs1      = r_id_ex.rs1;
  assign o_pipe_Rs2      = r_id_ex.rs2;
  assign o_pipe_Rd       = r_id_ex.rd;
  assign o_pipe_Funct3   = r_id_ex.funct3;
  assign o_pipe_ALUOp    = r_id_ex.alu_op;
  assign o_pipe_ALUSrcA  = r_id_ex.alu_src_a;
  assign o_pipe_ALUSrcB  = r_id_ex.alu_src_b;
  assign o_pipe_RegWrite = r_id_ex.reg_write;
  assign o_pipe_MemRead  = r_id_ex.mem_read;
  assign o_pipe_MemWrite = r_id_ex.mem_write;
  assign o_pipe_MemToReg = r_id_ex.mem_to_reg;
  assign o_pipe_Branch   = r_id_ex.branch;
  assign o_pipe_Jump     = r_id_ex.jump;
  assign o_pipe_Jalr     = r_id_ex.jalr;
  assign o_pipe_Illegal  = r_id_ex.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: hand-derived vector table, directed hazard/flush/reset
// sequences and randomized traffic against a behavioural decode model.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] i_pipe_PC = '0;
  logic [31:0] i_pipe_Instruction = '0;
  logic [4:0]  i_pipe_Reg1 = '0;
  logic [4:0]  i_pipe_Reg2 = '0;
  logic        i_wb_RegWrite = 1'b0;
  logic [4:0]  i_wb_Rd = '0;
  logic [31:0] i_wb_Data = '0;
  logic        i_ctr_Flush = 1'b0;
  logic        o_ctr_HoldPC, o_ctr_HoldIFIDReg;
  logic [31:0] o_pipe_PC, o_pipe_Rs1Data, o_pipe_Rs2Data, o_pipe_Imm;
  logic [4:0]  o_pipe_Rs1, o_pipe_Rs2, o_pipe_Rd;
  logic [2:0]  o_pipe_Funct3;
  logic [3:0]  o_pipe_ALUOp;
  logic        o_pipe_ALUSrcA, o_pipe_ALUSrcB, o_pipe_RegWrite, o_pipe_MemRead;
  logic        o_pipe_MemWrite, o_pipe_MemToReg, o_pipe_Branch, o_pipe_Jump;
  logic        o_pipe_Jalr, o_pipe_Illegal;

  decode_stage #(.WB_BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset),
    .i_pipe_PC(i_pipe_PC), .i_pipe_Instruction(i_pipe_Instruction),
    .i_pipe_Reg1(i_pipe_Reg1), .i_pipe_Reg2(i_pipe_Reg2),
    .i_wb_RegWrite(i_wb_RegWrite), .i_wb_Rd(i_wb_Rd), .i_wb_Data(i_wb_Data),
    .i_ctr_Flush(i_ctr_Flush),
    .o_ctr_HoldPC(o_ctr_HoldPC), .o_ctr_HoldIFIDReg(o_ctr_HoldIFIDReg),
    .o_pipe_PC(o_pipe_PC), .o_pipe_Rs1Data(o_pipe_Rs1Data), .o_pipe_Rs2Data(o_pipe_Rs2Data),
    .o_pipe_Imm(o_pipe_Imm), .o_pipe_Rs1(o_pipe_Rs1), .o_pipe_Rs2(o_pipe_Rs2),
    .o_pipe_Rd(o_pipe_Rd), .o_pipe_Funct3(o_pipe_Funct3), .o_pipe_ALUOp(o_pipe_ALUOp),
    .o_pipe_ALUSrcA(o_pipe_ALUSrcA), .o_pipe_ALUSrcB(o_pipe_ALUSrcB),
    .o_pipe_RegWrite(o_pipe_RegWrite), .o_pipe_MemRead(o_pipe_MemRead),
    .o_pipe_MemWrite(o_pipe_MemWrite), .o_pipe_MemToReg(o_pipe_MemToReg),
    .o_pipe_Branch(o_pipe_Branch), .o_pipe_Jump(o_pipe_Jump), .o_pipe_Jalr(o_pipe_Jalr),
    .o_pipe_Illegal(o_pipe_Illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  aluop;
    logic        srca, srcb, rw, mr, mw, m2r, br, j, jr, ill;
  } idex_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [9:0]  ctl;  // {srca, srcb, rw, mr, mw, m2r, br, j, jr, ill}
  } vec_t;

  idex_t       act, exp_q;
  logic [31:0] rf_m [32];
  logic        sq_m;
  int          checks = 0;
  int          failures = 0;

  assign act = {o_pipe_PC, o_pipe_Rs1Data, o_pipe_Rs2Data, o_pipe_Imm, o_pipe_Rs1, o_pipe_Rs2,
                o_pipe_Rd, o_pipe_Funct3, o_pipe_ALUOp, o_pipe_ALUSrcA, o_pipe_ALUSrcB,
                o_pipe_RegWrite, o_pipe_MemRead, o_pipe_MemWrite, o_pipe_MemToReg,
                o_pipe_Branch, o_pipe_Jump, o_pipe_Jalr, o_pipe_Illegal};

  task automatic chk32(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, a, e);
    end
  endtask

  task automatic chk_idex(input string name, input idex_t a, input idex_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%040h required=%040h", name, a, e);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    int s;
    s = int'(v << (32 - bits));
    return 32'(s >>> (32 - bits));
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] base [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    return base[f3] + ((alt && (f3 == 3'd0 || f3 == 3'd5)) ? 4'd1 : 4'd0);
  endfunction

  function automatic logic [31:0] rd_m(input logic [4:0] a, input logic we,
                                       input logic [4:0] wrd, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wrd == a) return wd;
    return rf_m[a];
  endfunction

  // What ID/EX should hold if this IF/ID word issues normally.
  function automatic idex_t ref_decode(input logic [31:0] pc, input logic [31:0] instr,
                                       input logic [31:0] d1, input logic [31:0] d2,
                                       input logic [4:0] r1, input logic [4:0] r2);
    idex_t e;
    logic  wr, u1, u2;
    e = '0; wr = 0; u1 = 0; u2 = 0;
    if (instr == 32'd0) return e;
    e.pc = pc; e.rs1d = d1; e.rs2d = d2; e.f3 = instr[14:12];
    case (instr[6:0])
      7'h37: begin e.aluop = 4'd10; e.srcb = 1; e.imm = {instr[31:12], 12'd0}; wr = 1; end
      7'h17: begin e.srca = 1; e.srcb = 1; e.imm = {instr[31:12], 12'd0}; wr = 1; end
      7'h6F: begin
        e.j = 1; e.srca = 1; wr = 1;
        e.imm = sx({11'd0, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, 21);
      end
      7'h67: begin e.j = 1; e.jr = 1; e.srcb = 1; e.imm = sx({20'd0, instr[31:20]}, 12); wr = 1; u1 = 1; end
      7'h63: begin
        e.br = 1; e.aluop = 4'd1; u1 = 1; u2 = 1;
        e.imm = sx({19'd0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, 13);
      end
      7'h03: begin e.mr = 1; e.m2r = 1; e.srcb = 1; e.imm = sx({20'd0, instr[31:20]}, 12); wr = 1; u1 = 1; end
      7'h23: begin e.mw = 1; e.srcb = 1; e.imm = sx({20'd0, instr[31:25], instr[11:7]}, 12); u1 = 1; u2 = 1; end
      7'h13: begin
        e.aluop = alu_of(instr[14:12], instr[30] && instr[14:12] == 3'd5);
        e.srcb = 1; e.imm = sx({20'd0, instr[31:20]}, 12); wr = 1; u1 = 1;
      end
      7'h33: begin e.aluop = alu_of(instr[14:12], instr[30]); wr = 1; u1 = 1; u2 = 1; end
      default: e.ill = 1;
    endcase
    e.rw  = wr;
    e.rd  = wr ? instr[11:7] : 5'd0;
    e.rs1 = u1 ? r1 : 5'd0;
    e.rs2 = u2 ? r2 : 5'd0;
    return e;
  endfunction

  // One cycle: drive IF/ID + WB + flush, check holds combinationally, then ID/EX after the edge.
  task automatic step(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                      input logic [4:0] wrd, input logic [31:0] wd, input logic fl,
                      output logic hold_d);
    idex_t cand;
    logic  hold_m;
    i_pipe_PC = pc; i_pipe_Instruction = instr;
    i_pipe_Reg1 = instr[19:15]; i_pipe_Reg2 = instr[24:20];
    i_wb_RegWrite = we; i_wb_Rd = wrd; i_wb_Data = wd; i_ctr_Flush = fl;
    #1;
    cand = ref_decode(pc, instr, rd_m(instr[19:15], we, wrd, wd), rd_m(instr[24:20], we, wrd, wd),
                      instr[19:15], instr[24:20]);
    hold_m = exp_q.mr && exp_q.rd != 5'd0 && (cand.rs1 == exp_q.rd || cand.rs2 == exp_q.rd) &&
             !fl && !sq_m;
    hold_d = o_ctr_HoldPC;
    chk32("hold_pc", 32'(o_ctr_HoldPC), 32'(hold_m));
    chk32("hold_ifid", 32'(o_ctr_HoldIFIDReg), 32'(hold_m));
    if (fl || sq_m || hold_m) exp_q = '0;
    else exp_q = cand;
    sq_m = fl;
    if (we && wrd != 5'd0) rf_m[wrd] = wd;
    @(posedge clk); #1;
    chk_idex("id_ex", act, exp_q);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk_idex("reset_idex", act, '0);
    chk32("reset_hold", 32'({o_ctr_HoldPC, o_ctr_HoldIFIDReg}), 32'd0);
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    exp_q = '0;
    sq_m = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    vec_t        vt [14];
    logic        h;
    logic [31:0] instr, pc;
    logic [6:0]  ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                              7'h33, 7'h03, 7'h0B, 7'h00};

    vt[0]  = '{32'h00500093, 32'h00000005, 4'd0,  10'b0110000000};  // ADDI x1,x0,5
    vt[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 4'd1,  10'b0000001000};  // BEQ x0,x0,-4
    vt[2]  = '{32'hFFFFFFFF, 32'h00000000, 4'd0,  10'b0000000001};  // illegal
    vt[3]  = '{32'h123450B7, 32'h12345000, 4'd10, 10'b0110000000};  // LUI
    vt[4]  = '{32'hFFFFF117, 32'hFFFFF000, 4'd0,  10'b1110000000};  // AUIPC
    vt[5]  = '{32'h402081B3, 32'h00000000, 4'd1,  10'b0010000000};  // SUB
    vt[6]  = '{32'h4030D213, 32'h00000403, 4'd7,  10'b0110000000};  // SRAI
    vt[7]  = '{32'h0020A423, 32'h00000008, 4'd0,  10'b0100100000};  // SW
    vt[8]  = '{32'h001000EF, 32'h00000800, 4'd0,  10'b1010000100};  // JAL
    vt[9]  = '{32'hFFF100E7, 32'hFFFFFFFF, 4'd0,  10'b0110000110};  // JALR
    vt[10] = '{32'h0000A103, 32'h00000000, 4'd0,  10'b0111010000};  // LW
    vt[11] = '{32'hFFF0B293, 32'hFFFFFFFF, 4'd4,  10'b0110000000};  // SLTIU
    vt[12] = '{32'h0020C1B3, 32'h00000000, 4'd5,  10'b0010000000};  // XOR
    vt[13] = '{32'h0020F1B3, 32'h00000000, 4'd9,  10'b0010000000};  // AND

    do_reset();
    for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, h);

    // ADDI at PC 0x10
    step(32'h10, 32'h00500093, 1'b0, 5'd0, 32'h0, 1'b0, h);
    chk32("addi_rd", 32'(o_pipe_Rd), 32'd1);
    chk32("addi_pc", o_pipe_PC, 32'h10);

    // Same-cycle write-back bypass, and x0 never bypasses
    step(32'h14, 32'h00528333, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, h);
    chk32("bypass_rs1", o_pipe_Rs1Data, 32'hDEADBEEF);
    chk32("bypass_rs2", o_pipe_Rs2Data, 32'hDEADBEEF);
    step(32'h18, 32'h000003B3, 1'b1, 5'd0, 32'h1234, 1'b0, h);
    chk32("x0_read", o_pipe_Rs1Data, 32'h0);

    foreach (vt[i]) begin
      step(32'h100 + 32'(i * 4), vt[i].instr, 1'b0, 5'd0, 32'h0, 1'b0, h);
      chk32("vec_imm", o_pipe_Imm, vt[i].imm);
      chk32("vec_alu", 32'(o_pipe_ALUOp), 32'(vt[i].alu));
      chk32("vec_ctl", 32'({o_pipe_ALUSrcA, o_pipe_ALUSrcB, o_pipe_RegWrite, o_pipe_MemRead,
                            o_pipe_MemWrite, o_pipe_MemToReg, o_pipe_Branch, o_pipe_Jump,
                            o_pipe_Jalr, o_pipe_Illegal}), 32'(vt[i].ctl));
      step(32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, h);
    end

    // Load-use: one stall cycle, then the dependent ADD issues
    step(32'h200, 32'h0000A103, 1'b0, 5'd0, 32'h0, 1'b0, h);
    step(32'h204, 32'h002101B3, 1'b0, 5'd0, 32'h0, 1'b0, h);
    chk32("lu_hold", 32'(h), 32'd1);
    chk32("lu_bubble_rw", 32'(o_pipe_RegWrite), 32'd0);
    step(32'h204, 32'h002101B3, 1'b0, 5'd0, 32'h0, 1'b0, h);
    chk32("lu_release", 32'(h), 32'd0);
    chk32("lu_issue_rd", 32'(o_pipe_Rd), 32'd3);
    step(32'h208, 32'h0000A103, 1'b0, 5'd0, 32'h0, 1'b0, h);
    step(32'h20C, 32'h001081B3, 1'b0, 5'd0, 32'h0, 1'b0, h);
    chk32("no_dep_hold", 32'(h), 32'd0);

    // Flush during a load-use stall: two bubbles, third instruction issues
    step(32'h300, 32'h0000A103, 1'b0, 5'd0, 32'h0, 1'b0, h);
    step(32'h304, 32'h002101B3, 1'b0, 5'd0, 32'h0, 1'b1, h);
    chk32("flush_hold", 32'(h), 32'd0);
    step(32'h308, 32'h00500093, 1'b0, 5'd0, 32'h0, 1'b0, h);
    chk32("squash_rw", 32'(o_pipe_RegWrite), 32'd0);
    step(32'h400, 32'h00500093, 1'b0, 5'd0, 32'h0, 1'b0, h);
    chk32("after_squash_rw", 32'(o_pipe_RegWrite), 32'd1);

    // Back-to-back flushes, then reset mid-squash and mid-stall
    step(32'h500, 32'h00500093, 1'b0, 5'd0, 32'h0, 1'b1, h);
    step(32'h504, 32'h00500093, 1'b0, 5'd0, 32'h0, 1'b1, h);
    step(32'h508, 32'h00500093, 1'b0, 5'd0, 32'h0, 1'b0, h);
    step(32'h600, 32'h00500093, 1'b0, 5'd0, 32'h0, 1'b1, h);
    do_reset();
    step(32'h604, 32'h00500093, 1'b0, 5'd0, 32'h0, 1'b0, h);
    chk32("post_reset_issue", 32'(o_pipe_RegWrite), 32'd1);
    step(32'h700, 32'h0000A103, 1'b0, 5'd0, 32'h0, 1'b0, h);
    i_pipe_Instruction = 32'h002101B3; i_pipe_Reg1 = 5'd2; i_pipe_Reg2 = 5'd2;
    do_reset();

    // Randomized traffic; a held IF/ID is re-presented like a real fetch stage would
    instr = 32'h0; pc = 32'h0; h = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!h) begin
        logic [6:0] op;
        op = ops[$urandom_range(0, 11)];
        instr = $urandom;
        instr[6:0] = op;
        instr[11:7] = 5'($urandom_range(0, 3));
        instr[19:15] = 5'($urandom_range(0, 3));
        instr[24:20] = 5'($urandom_range(0, 3));
        if (op == 7'h00) instr = 32'h0;
        pc = $urandom;
      end
      step(pc, instr, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
           ($urandom_range(0, 11) == 0), h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
